median_frame_ctrl: RTL and testbench
====================================

// Module: median_frame_ctrl
// PURPOSE
//  Frame-level sequencer for the median filter windowing datapath.
//  - On start, clears the window address generator, then issues one read-enable per memory word for the whole frame.
//  - Tracks read latency and filter latency with a valid pipeline, then generates output-memory write strobes and addresses.
//  - Drains the pipeline and signals done.
//  - Sits between the host/top-level control and the window address generator, line memories and median pipeline.
// PARAMETERS
//  IMG_WIDTH      234  image width in pixels
//  IMG_HEIGHT     234  image height in lines (>=3)
//  PIX_PER_WORD   4    pixels per memory word; COLS = IMG_WIDTH/PIX_PER_WORD (integer division)
//  RD_LATENCY     1    line-memory read latency in cycles (>=1)
//  PIPE_LATENCY   10   median datapath latency in cycles (>=1)
//  LUT_ADDR_WIDTH 10   output memory address width
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous reset, active-high
//  start        in   1   begin frame; sampled only in IDLE
//  abort        in   1   synchronous abort, any state
//  hold         in   1   back-pressure; suppresses read issue in RUN
//  busy         out  1   high whenever state != IDLE
//  done         out  1   one-cycle pulse at end of frame
//  addr_clr     out  1   one-cycle clear to window address generator
//  addr_en      out  1   advance/read enable to address generator
//  line_end     out  1   addr_en on last column of a window line
//  col_count    out  10  current column word index 0..COLS-1
//  line_count   out  10  current window line index 0..IMG_HEIGHT-3
//  window_valid out  1   window data valid at median input
//  out_valid    out  1   output memory write enable
//  out_addr     out  LUT_ADDR_WIDTH  output memory write address
// BEHAVIOUR
//  Reset: state=IDLE; all counters, out_addr and valid pipe = 0; all outputs 0.
//  States:
//  - IDLE:  start=1 -> CLEAR.
//  - CLEAR: 1 cycle. addr_clr=1. col/line/out_addr <= 0. -> RUN.
//  - RUN:   addr_en = !hold, combinational.
//      - On addr_en, col_count increments; at COLS-1 it wraps to 0 and line_count increments.
//      - line_end = addr_en && col_count==COLS-1.
//      - Last issue (col==COLS-1, line==IMG_HEIGHT-3, addr_en=1) -> FLUSH.
//      - Total issues per frame = COLS*(IMG_HEIGHT-2).
//  - FLUSH: addr_en=0. When the valid pipe is all zero -> DONE.
//  - DONE:  done=1 for one cycle. -> IDLE. Counters hold their final values.
//  Valid pipe: shift register of RD_LATENCY+PIPE_LATENCY bits.
//  - vpipe[0] <= addr_en; it shifts every cycle and is never stalled by hold.
//  - window_valid = vpipe[RD_LATENCY-1].
//  - out_valid = vpipe[RD_LATENCY+PIPE_LATENCY-1].
//  - out_addr increments after each out_valid cycle and wraps modulo 2^LUT_ADDR_WIDTH.
//  Latency: first out_valid occurs RD_LATENCY+PIPE_LATENCY cycles after the first addr_en.
//  - With no hold, done = last issue cycle + RD_LATENCY+PIPE_LATENCY+2.
//  Boundaries:
//  - start while busy: ignored.
//  - start and abort in the same cycle in IDLE: abort wins, stay IDLE.
//  - abort (any state): next state IDLE; vpipe, counters and out_addr cleared; no done pulse.
//  - rst mid-frame: immediate return to reset state.
//  - hold in CLEAR/FLUSH: no effect.
//  - hold through the last column: the last issue waits and the FLUSH transition waits with it.
//  - COLS==1: every issue is a line_end.
// TESTING
//  Params: W=16, H=5, PPW=4, RD=1, PIPE=3 (COLS=4, 12 issues). start=1 sampled at edge 0:
//  1 Nominal: CLEAR cycle 1; addr_en cycles 2..13; line_end at 5, 9, 13; out_valid 6..17; done at 19; out_addr=12.
//  2 Hold: hold=1 for cycles 4..6 -> addr_en low 4..6; 12 issues total; last at 16; done at 22; no dropped or duplicate out_valid.
//  3 Abort at cycle 8 -> IDLE at 9; busy=0; out_valid never asserts after 9; no done; out_addr=0; new start runs as test 1.
//  4 start pulsed at cycles 5 and 10 during the frame -> ignored; exactly one done, at 19.
//  5 Async rst at cycle 7 -> all outputs 0 immediately; after release, start gives nominal timing.
//  6 Abort and start together in IDLE -> remains IDLE; addr_clr never asserted.

Source files
------------

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the median filter windowing datapath.
// The sequencer clears the window address generator and then issues one read per
// memory word for the whole frame. A valid shift register tracks the read latency
// and the filter latency, and produces the output-memory write strobes. After the
// last issue the controller drains that pipe, then pulses done.
//
// Handshake: there is no valid/ready pair. hold is a level-sensitive back-pressure
// input. While hold is high in RUN, no read is issued (addr_en=0). Work that is
// already in the valid pipe keeps moving, because the pipe is never stalled.
module median_frame_ctrl #(
  parameter int IMG_WIDTH      = 234,
  parameter int IMG_HEIGHT     = 234,
  parameter int PIX_PER_WORD   = 4,
  parameter int RD_LATENCY     = 1,
  parameter int PIPE_LATENCY   = 10,
  parameter int LUT_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      hold,
  output logic                      busy,
  output logic                      done,
  output logic                      addr_clr,
  output logic                      addr_en,
  output logic                      line_end,
  output logic [9:0]                col_count,
  output logic [9:0]                line_count,
  output logic                      window_valid,
  output logic                      out_valid,
  output logic [LUT_ADDR_WIDTH-1:0] out_addr,
  output logic [2:0]                state_dbg
);

  localparam int COLS = IMG_WIDTH / PIX_PER_WORD;
  localparam int VL   = RD_LATENCY + PIPE_LATENCY;
  localparam logic [9:0] COL_LAST  = 10'(COLS - 1);
  localparam logic [9:0] LINE_LAST = 10'(IMG_HEIGHT - 3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [VL-1:0]   vpipe;

  assign state_dbg    = state;
  assign window_valid = vpipe[RD_LATENCY-1];
  assign out_valid    = vpipe[VL-1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and per-state strobes; abort overrides any transition
  always_comb begin
    state_n  = state;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    addr_clr = 1'b0;
    addr_en  = 1'b0;
    line_end = 1'b0;
    case (state)
      S_IDLE:  if (start) state_n = S_CLEAR;
      S_CLEAR: begin
        addr_clr = 1'b1;
        state_n  = S_RUN;
      end
      S_RUN: begin
        addr_en  = !hold;
        line_end = !hold && (col_count == COL_LAST);
        if (!hold && col_count == COL_LAST && line_count == LINE_LAST)
          state_n = S_FLUSH;
      end
      S_FLUSH: if (vpipe == '0) state_n = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  // Column/line position of the next read; wraps columns into lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_count  <= '0;
      line_count <= '0;
    end else if (abort || state == S_CLEAR) begin
      col_count  <= '0;
      line_count <= '0;
    end else if (addr_en) begin
      if (col_count == COL_LAST) begin
        col_count  <= '0;
        line_count <= line_count + 10'd1;
      end else begin
        col_count <= col_count + 10'd1;
      end
    end
  end

  // Valid pipe: one bit per issued read, shifted every cycle regardless of hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        vpipe <= '0;
    else if (abort) vpipe <= '0;
    else            vpipe <= {vpipe[VL-2:0], addr_en};
  end

  // Output write address, advanced after every write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             out_addr <= '0;
    else if (abort || state == S_CLEAR)  out_addr <= '0;
    else if (out_valid)                  out_addr <= out_addr + 1'b1;
  end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Testbench for median_frame_ctrl.
// A reference model works out when each frame event should happen, using the hold
// pattern and the frame geometry. It pushes those events into expected queues.
// A separate monitor on the falling clock edge pops each queue whenever the DUT
// presents the matching strobe, and compares the two.
module tb_median_frame_ctrl;
  localparam int W = 16, H = 5, PPW = 4, RD = 1, PIPE = 3, AW = 10;
  localparam int COLS = W / PPW;
  localparam int N    = COLS * (H - 2);
  localparam int L    = RD + PIPE;

  typedef struct {
    int   c;
    int   col;
    int   line;
    logic le;
  } iss_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, start, abort, hold;
  logic busy, done, addr_clr, addr_en, line_end, window_valid, out_valid;
  logic [9:0] col_count, line_count;
  logic [AW-1:0] out_addr;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  median_frame_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_PER_WORD(PPW),
    .RD_LATENCY(RD), .PIPE_LATENCY(PIPE), .LUT_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .busy(busy), .done(done), .addr_clr(addr_clr), .addr_en(addr_en),
    .line_end(line_end), .col_count(col_count), .line_count(line_count),
    .window_valid(window_valid), .out_valid(out_valid), .out_addr(out_addr),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_q[$];
  int   exp_ov_cyc[$];
  iss_t iss_q[$];
  int   exp_wv_cyc[$];
  int   exp_done_cyc[$];
  int   exp_clr_cyc[$];
  int   busy_from = -1;
  int   busy_to   = -2;
  int   last_done_cyc = -1;
  bit   mon_en = 1'b0;
  iss_t e_iss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_expect();
    exp_q.delete(); exp_ov_cyc.delete(); iss_q.delete();
    exp_wv_cyc.delete(); exp_done_cyc.delete(); exp_clr_cyc.delete();
    busy_from = -1;
    busy_to   = -2;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      // expected events whose cycle has passed were never presented
      if (exp_clr_cyc.size() > 0 && exp_clr_cyc[0] < cyc) begin
        check("addr_clr_missing", 0, 1); void'(exp_clr_cyc.pop_front());
      end
      if (iss_q.size() > 0 && iss_q[0].c < cyc) begin
        check("addr_en_missing", 0, 1); void'(iss_q.pop_front());
      end
      if (exp_wv_cyc.size() > 0 && exp_wv_cyc[0] < cyc) begin
        check("window_valid_missing", 0, 1); void'(exp_wv_cyc.pop_front());
      end
      if (exp_ov_cyc.size() > 0 && exp_ov_cyc[0] < cyc) begin
        check("out_valid_missing", 0, 1);
        void'(exp_ov_cyc.pop_front()); void'(exp_q.pop_front());
      end
      if (exp_done_cyc.size() > 0 && exp_done_cyc[0] < cyc) begin
        check("done_missing", 0, 1); void'(exp_done_cyc.pop_front());
      end

      check("busy", busy, (cyc >= busy_from && cyc <= busy_to));

      if (addr_clr) begin
        if (exp_clr_cyc.size() == 0) check("addr_clr_unexpected", 1, 0);
        else check("addr_clr_cycle", cyc, exp_clr_cyc.pop_front());
      end
      if (addr_en) begin
        if (iss_q.size() == 0) check("addr_en_unexpected", 1, 0);
        else begin
          e_iss = iss_q.pop_front();
          check("addr_en_cycle", cyc, e_iss.c);
          check("col_count", col_count, e_iss.col);
          check("line_count", line_count, e_iss.line);
          check("line_end", line_end, e_iss.le);
        end
      end else if (line_end) begin
        check("line_end_without_addr_en", 1, 0);
      end
      if (window_valid) begin
        if (exp_wv_cyc.size() == 0) check("window_valid_unexpected", 1, 0);
        else check("window_valid_cycle", cyc, exp_wv_cyc.pop_front());
      end
      if (out_valid) begin
        if (exp_ov_cyc.size() == 0) check("out_valid_unexpected", 1, 0);
        else begin
          check("out_valid_cycle", cyc, exp_ov_cyc.pop_front());
          check("out_addr", out_addr, exp_q.pop_front());
        end
      end
      if (done) begin
        last_done_cyc = cyc;
        if (exp_done_cyc.size() == 0) check("done_unexpected", 1, 0);
        else check("done_cycle", cyc, exp_done_cyc.pop_front());
      end
    end
  end

  // ---------------- driver + reference model ----------------
  // hold_mode: 0 random with hold_pct, 1 hold high for relative cycles 4..6
  // abort_at:  0 none, -1 random, >0 fixed relative cycle
  task automatic run_frame(input int hold_pct, input int hold_mode, input int abort_at,
                           input bit stray, output int p_o, output int dn_o);
    bit hp[200];
    int ik[N];
    int p, n, last, dn, a, stop;
    for (int k = 0; k < 200; k++) begin
      if (hold_mode == 1) hp[k] = (k >= 4 && k <= 6);
      else hp[k] = (k < 100) && ($urandom_range(99) < hold_pct);
    end
    p = cyc;
    // issue i happens on the i-th RUN cycle (RUN begins 2 cycles after start) with hold low
    n = 0;
    for (int k = 2; k < 200 && n < N; k++)
      if (!hp[k]) begin ik[n] = k; n++; end
    last = ik[N-1];
    dn   = last + L + 2;
    if (abort_at < 0)      a = $urandom_range(dn - 1, 1);
    else if (abort_at > 0) a = abort_at;
    else                   a = 0;

    exp_clr_cyc.push_back(p + 1);
    for (int i = 0; i < N; i++) begin
      if (a == 0 || ik[i] <= a)
        iss_q.push_back('{c: p + ik[i], col: i % COLS, line: i / COLS, le: (i % COLS) == COLS - 1});
      if (a == 0 || ik[i] + RD <= a) exp_wv_cyc.push_back(p + ik[i] + RD);
      if (a == 0 || ik[i] + L <= a) begin
        exp_ov_cyc.push_back(p + ik[i] + L);
        exp_q.push_back(AW'(i));
      end
    end
    if (a == 0) exp_done_cyc.push_back(p + dn);
    busy_from = p + 1;
    busy_to   = (a == 0) ? p + dn : p + a;
    stop      = (a == 0) ? dn : a;

    start = 1'b1; hold = hp[0]; abort = 1'b0;
    for (int k = 1; k <= stop; k++) begin
      @(posedge clk); #1;
      start = stray && (k == 5 || k == 10);
      hold  = hp[k];
      abort = (a != 0) && (k == a);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; hold = $urandom_range(1);
    if (a != 0) begin
      check("abort_busy", busy, 0);
      check("abort_out_addr", out_addr, 0);
      check("abort_col_count", col_count, 0);
      check("abort_state", state_dbg, 0);
    end
    repeat (L + 2) begin @(posedge clk); #1; hold = $urandom_range(1); end
    p_o  = p;
    dn_o = dn;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_addr_en"}, addr_en, 0);
    check({tag, "_addr_clr"}, addr_clr, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_window_valid"}, window_valid, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_addr"}, out_addr, 0);
    check({tag, "_col_count"}, col_count, 0);
    check({tag, "_line_count"}, line_count, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p, dn;
    rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");
    mon_en = 1'b1;
    @(posedge clk); #1;

    // nominal frame straight out of reset
    run_frame(0, 0, 0, 1'b0, p, dn);
    check("nominal_done_rel", last_done_cyc - p, 19);
    check("nominal_final_out_addr", out_addr, N);

    // directed hold window
    run_frame(0, 1, 0, 1'b0, p, dn);
    check("hold_done_rel", last_done_cyc - p, 22);

    // abort mid-run, then a clean frame
    run_frame(0, 0, 8, 1'b0, p, dn);
    run_frame(0, 0, 0, 1'b0, p, dn);
    check("after_abort_done_rel", last_done_cyc - p, 19);

    // stray start pulses while busy
    run_frame(0, 0, 0, 1'b1, p, dn);
    check("stray_start_done_rel", last_done_cyc - p, 19);

    // asynchronous reset in the middle of a frame
    start = 1'b1; hold = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    mon_en = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("async_rst");
    check("async_rst_state", state_dbg, 0);
    clear_expect();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 mon_en = 1'b1;
    run_frame(0, 0, 0, 1'b0, p, dn);
    check("after_rst_done_rel", last_done_cyc - p, 19);

    // start and abort together in IDLE: no frame, no addr_clr
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_state", state_dbg, 0);
    repeat (4) @(posedge clk);
    #1;

    // randomized frames: hold density, optional abort, optional stray starts
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(50), 0, ($urandom_range(99) < 30) ? -1 : 0,
                1'(($urandom_range(1))), p, dn);
    end

    repeat (3) @(posedge clk);
    #1;
    check("leftover_expected",
          exp_q.size() + iss_q.size() + exp_wv_cyc.size() + exp_done_cyc.size() + exp_clr_cyc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
